key_ctrl_bank: RTL and testbench
================================

Name: key_ctrl_bank

Overview:
Parametrised bank of NUM_KEYS push-button channels. It generalises the fixed seven-key debounce-and-pulse logic in the video stitching control path. Per key it provides:
- input synchronisation;
- press and release debouncing;
- long-press detection;
- auto-repeat;
- a per-key wrap-or-saturate control counter.

The counters drive image-adjust blocks such as brightness and colour gain, which take ctrl_val slices directly.

Parameters:
NUM_KEYS, 7, number of key channels
KEY_ACTIVE_LOW, 1, 1 means key pressed when pin is 0
DEBOUNCE_CYC, 500000, consecutive active cycles (at key_s) needed to accept a press; must be ≥2
REL_CYC, 500000, consecutive inactive cycles needed to accept a release; must be ≥2
LONG_CYC, 25000000, continuous pressed cycles to flag a long press; must be > DEBOUNCE_CYC
REPEAT_CYC, 5000000, auto-repeat period after long press; must be ≥2
REPEAT_EN, {NUM_KEYS{1'b1}}, per-key mask; repeat pulses also increment the counter
CNT_W, 3, width of each per-key control counter
SAT_MODE, 0, 0 = counter wraps max→0; 1 = counter saturates at 2^CNT_W-1

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous, active-low reset
key_in  in  NUM_KEYS  raw asynchronous key pins
cnt_clr  in  1  synchronous clear of all ctrl_val counters
key_level  out  NUM_KEYS  debounced pressed level
press_pulse  out  NUM_KEYS  1-cycle strobe on accepted press
long_pulse  out  NUM_KEYS  1-cycle strobe on long-press detection
repeat_pulse  out  NUM_KEYS  1-cycle strobe on each auto-repeat
release_pulse  out  NUM_KEYS  1-cycle strobe on accepted release
ctrl_val  out  NUM_KEYS*CNT_W  per-key counters; key i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset is asynchronous (sys_rst_n low). It forces all synchroniser flops to the inactive level, all FSMs to IDLE, all timers to 0, and all outputs to 0, including ctrl_val.
- Synchronisation: 2-flop synchroniser per key, with polarity normalised so key_s=1 means pressed.
- Timer widths: press timer and repeat timer are $clog2(LONG_CYC+1) bits each; release timer is $clog2(REL_CYC+1) bits.
- Per-key FSM states:
  - IDLE: key_level=0. If key_s=1 → ARM, with press timer=1.
  - ARM: If key_s=0 → IDLE and timer=0; no pulse is emitted (glitch reject). Otherwise the timer increments. When the timer reaches DEBOUNCE_CYC → HELD, and press_pulse is asserted in that same cycle's registered output.
  - HELD: key_level=1. The press timer increments, saturating at LONG_CYC. On reaching LONG_CYC → REPEAT, long_pulse=1 for one cycle, repeat timer=0. If key_s=0 → RELEASE, with release timer=1 and the press timer frozen.
  - REPEAT: key_level=1. The repeat timer increments. On reaching REPEAT_CYC, repeat_pulse=1 and the repeat timer returns to 0. If key_s=0 → RELEASE, with the repeat timer frozen.
  - RELEASE: key_level stays 1. The release timer increments while key_s=0. If key_s=1 before REL_CYC is reached, return to the origin state (HELD or REPEAT) and resume the frozen timers. On reaching REL_CYC → IDLE, release_pulse=1, all timers=0.
- Pulse timing, measured from the first key_s=1 cycle k with continuous press:
  - press_pulse at cycle k+DEBOUNCE_CYC;
  - long_pulse at k+LONG_CYC, excluding any cycles spent in RELEASE;
  - repeat_pulse at k+LONG_CYC+n*REPEAT_CYC, for n≥1.
- Counter update:
  - ctrl_val[i] updates the cycle after press_pulse[i], or after repeat_pulse[i] when REPEAT_EN[i]=1. Each event adds 1.
  - On overflow, SAT_MODE=0 wraps to 0; SAT_MODE=1 holds at max.
  - long_pulse never increments the counter.
- cnt_clr: clears every counter on the next edge. It has priority over a simultaneous increment; that increment is lost.
- Channels are fully independent. Simultaneous events on different keys are all honoured in the same cycle.
- Reset asserted mid-press returns the key to IDLE. The key must then re-debounce from key_s; no pulse is emitted for the interrupted press.

Test Plan:
Parameters for all tests: NUM_KEYS=2, DEBOUNCE_CYC=4, REL_CYC=3, LONG_CYC=20, REPEAT_CYC=5, CNT_W=3.
1. Key0 pin held pressed; key_s=1 from cycle 10 → press_pulse[0] at cycle 14, key_level[0]=1 at 14, ctrl_val[0]=1 at 15. Pin released; key_s=0 from cycle 16 → release_pulse[0] at cycle 19, key_level[0]=0.
2. Glitch: key_s=1 for 3 cycles, then 0 → no pulses, key_level stays 0, ctrl_val unchanged.
3. Hold key1; key_s=1 from cycle 0 → press_pulse at 4, long_pulse at 20, repeat_pulse at 25, 30 and 35. ctrl_val[1] reads 4 after cycle 36.
4. Release bounce: while HELD, key_s=0 for 2 cycles then 1 → no release_pulse, key_level stays 1. long_pulse is delayed by 2 cycles, to k+22.
5. Overflow: 9 presses with SAT_MODE=0 → ctrl_val 0→7→0→1. Same sequence with SAT_MODE=1 → ctrl_val holds at 7.
6. cnt_clr asserted in the same cycle as press_pulse[0] → ctrl_val[0]=0 next cycle. Then sys_rst_n pulses low mid-HELD → all outputs 0; a later full press yields ctrl_val[0]=1.

Source files
------------

// File: rtl/key_ctrl_bank_if.sv
// Interface for the key_ctrl_bank push-button bank.
// It groups the raw key pins and the counter clear (driven by the master) with
// the debounced level, the event strobes and the packed control counters
// (driven by the slave, which is the bank itself).
//   key_in        raw asynchronous key pins, one per channel
//   cnt_clr       synchronous clear of every ctrl_val counter
//   key_level     debounced pressed level
//   press_pulse   1-cycle strobe when a press is accepted
//   long_pulse    1-cycle strobe when a long press is detected
//   repeat_pulse  1-cycle strobe on each auto-repeat
//   release_pulse 1-cycle strobe when a release is accepted
//   ctrl_val      per-key counters; key i occupies [i*CNT_W +: CNT_W]
interface key_ctrl_bank_if #(
    parameter int NUM_KEYS = 7,
    parameter int CNT_W    = 3
);
    logic [NUM_KEYS-1:0]       key_in;
    logic                      cnt_clr;
    logic [NUM_KEYS-1:0]       key_level;
    logic [NUM_KEYS-1:0]       press_pulse;
    logic [NUM_KEYS-1:0]       long_pulse;
    logic [NUM_KEYS-1:0]       repeat_pulse;
    logic [NUM_KEYS-1:0]       release_pulse;
    logic [NUM_KEYS*CNT_W-1:0] ctrl_val;

    modport master (
        output key_in, cnt_clr,
        input  key_level, press_pulse, long_pulse, repeat_pulse, release_pulse, ctrl_val
    );

    modport slave (
        input  key_in, cnt_clr,
        output key_level, press_pulse, long_pulse, repeat_pulse, release_pulse, ctrl_val
    );
endinterface

// File: rtl/key_ctrl_bank.sv
// key_ctrl_bank: bank of NUM_KEYS independent push-button channels.
// Each channel synchronises its pin, debounces press and release, flags a
// long press, generates auto-repeat strobes and keeps a small wrap-or-saturate
// control counter that the image-adjust blocks consume directly.
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous, active-low reset
//   bus        key_ctrl_bank_if.slave (pins and clear in; level, strobes, counters out)
//
// Per-key FSM:
//   state   | meaning
//   IDLE    | released, waiting for key_s
//   ARM     | debouncing a press; press timer counts key_s cycles
//   HELD    | accepted press, counting towards long press
//   REPEAT  | long press seen, repeat timer running
//   RELEASE | debouncing a release; returns to HELD/REPEAT on bounce
module key_ctrl_bank #(
    parameter int                  NUM_KEYS       = 7,
    parameter bit                  KEY_ACTIVE_LOW = 1'b1,
    parameter int                  DEBOUNCE_CYC   = 500000,
    parameter int                  REL_CYC        = 500000,
    parameter int                  LONG_CYC       = 25000000,
    parameter int                  REPEAT_CYC     = 5000000,
    parameter logic [NUM_KEYS-1:0] REPEAT_EN      = {NUM_KEYS{1'b1}},
    parameter int                  CNT_W          = 3,
    parameter bit                  SAT_MODE       = 1'b0
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    key_ctrl_bank_if.slave bus
);
    localparam int PT_W = $clog2(LONG_CYC + 1);
    localparam int LT_W = $clog2(REL_CYC + 1);
    localparam logic [PT_W-1:0]  DEB_T  = PT_W'(DEBOUNCE_CYC);
    localparam logic [PT_W-1:0]  LONG_T = PT_W'(LONG_CYC);
    localparam logic [PT_W-1:0]  REP_T  = PT_W'(REPEAT_CYC);
    localparam logic [LT_W-1:0]  REL_T  = LT_W'(REL_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Pin level that means "not pressed"; synchroniser flops reset to it.
    localparam logic [NUM_KEYS-1:0] PIN_IDLE = {NUM_KEYS{KEY_ACTIVE_LOW}};

    typedef enum logic [2:0] {IDLE, ARM, HELD, REPEAT, RELEASE} state_t;

    logic [NUM_KEYS-1:0] sync_1, sync_2, key_s;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_1 <= PIN_IDLE;
            sync_2 <= PIN_IDLE;
        end else begin
            sync_1 <= bus.key_in;
            sync_2 <= sync_1;
        end
    end

    // key_s = 1 means pressed regardless of pin polarity.
    assign key_s = sync_2 ^ PIN_IDLE;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        state_t           state, state_nxt;
        logic [PT_W-1:0]  press_tmr, press_tmr_nxt, press_inc;
        logic [PT_W-1:0]  rep_tmr, rep_tmr_nxt, rep_inc;
        logic [LT_W-1:0]  rel_tmr, rel_tmr_nxt, rel_inc;
        logic             from_rep, from_rep_nxt;
        logic             run_held, run_rep;
        logic             press_q, press_nxt, long_q, long_nxt;
        logic             rep_q, rep_nxt, rel_q, rel_nxt;
        logic [CNT_W-1:0] cnt;
        logic             cnt_inc;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state     <= IDLE;
                press_tmr <= '0;
                rep_tmr   <= '0;
                rel_tmr   <= '0;
                from_rep  <= 1'b0;
                press_q   <= 1'b0;
                long_q    <= 1'b0;
                rep_q     <= 1'b0;
                rel_q     <= 1'b0;
            end else begin
                state     <= state_nxt;
                press_tmr <= press_tmr_nxt;
                rep_tmr   <= rep_tmr_nxt;
                rel_tmr   <= rel_tmr_nxt;
                from_rep  <= from_rep_nxt;
                press_q   <= press_nxt;
                long_q    <= long_nxt;
                rep_q     <= rep_nxt;
                rel_q     <= rel_nxt;
            end
        end

        // Press timer saturates at LONG_CYC so it can sit frozen in REPEAT.
        assign press_inc = (press_tmr == LONG_T) ? press_tmr : press_tmr + PT_W'(1);
        assign rep_inc   = rep_tmr + PT_W'(1);
        assign rel_inc   = rel_tmr + LT_W'(1);

        always_comb begin
            state_nxt     = state;
            press_tmr_nxt = press_tmr;
            rep_tmr_nxt   = rep_tmr;
            rel_tmr_nxt   = rel_tmr;
            from_rep_nxt  = from_rep;
            press_nxt     = 1'b0;
            long_nxt      = 1'b0;
            rep_nxt       = 1'b0;
            rel_nxt       = 1'b0;
            run_held      = 1'b0;
            run_rep       = 1'b0;

            unique case (state)
                IDLE: begin
                    if (key_s[i]) begin
                        state_nxt     = ARM;
                        press_tmr_nxt = PT_W'(1);
                    end
                end
                ARM: begin
                    if (!key_s[i]) begin
                        state_nxt     = IDLE;
                        press_tmr_nxt = '0;
                    end else begin
                        press_tmr_nxt = press_inc;
                        if (press_inc == DEB_T) begin
                            state_nxt = HELD;
                            press_nxt = 1'b1;
                        end
                    end
                end
                HELD, REPEAT: begin
                    if (!key_s[i]) begin
                        state_nxt    = RELEASE;
                        rel_tmr_nxt  = LT_W'(1);
                        from_rep_nxt = (state == REPEAT);
                    end else if (state == HELD) begin
                        run_held = 1'b1;
                    end else begin
                        run_rep = 1'b1;
                    end
                end
                RELEASE: begin
                    if (key_s[i]) begin
                        // Bounce: the cycle that brings key_s back resumes counting.
                        rel_tmr_nxt = '0;
                        run_held    = !from_rep;
                        run_rep     = from_rep;
                    end else begin
                        rel_tmr_nxt = rel_inc;
                        if (rel_inc == REL_T) begin
                            state_nxt     = IDLE;
                            rel_nxt       = 1'b1;
                            press_tmr_nxt = '0;
                            rep_tmr_nxt   = '0;
                            rel_tmr_nxt   = '0;
                            from_rep_nxt  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (run_held) begin
                state_nxt     = HELD;
                press_tmr_nxt = press_inc;
                if (press_inc == LONG_T) begin
                    state_nxt   = REPEAT;
                    long_nxt    = 1'b1;
                    rep_tmr_nxt = '0;
                end
            end
            if (run_rep) begin
                state_nxt = REPEAT;
                if (rep_inc == REP_T) begin
                    rep_nxt     = 1'b1;
                    rep_tmr_nxt = '0;
                end else begin
                    rep_tmr_nxt = rep_inc;
                end
            end
        end

        // Counter reacts to the registered strobes, i.e. one cycle after them.
        assign cnt_inc = press_q | (rep_q & REPEAT_EN[i]);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt <= '0;
            end else if (bus.cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                if (SAT_MODE && (cnt == CNT_MAX)) begin
                    cnt <= cnt;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign bus.key_level[i]     = (state == HELD) || (state == REPEAT) || (state == RELEASE);
        assign bus.press_pulse[i]   = press_q;
        assign bus.long_pulse[i]    = long_q;
        assign bus.repeat_pulse[i]  = rep_q;
        assign bus.release_pulse[i] = rel_q;
        assign bus.ctrl_val[i*CNT_W +: CNT_W] = cnt;
    end
endmodule

// File: tb/tb_key_ctrl_bank.sv
// Testbench for key_ctrl_bank: two instances (wrapping counters with repeat
// increment on both keys; saturating counters with repeat increment on key 0
// only) share the same pins. A directed table of hand-derived expectations is
// followed by random pin activity checked every cycle against an event model.
module tb_key_ctrl_bank;
    localparam int NK  = 2;
    localparam int DEB = 4;
    localparam int REL = 3;
    localparam int LNG = 20;
    localparam int RPT = 5;
    localparam int CW  = 3;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [1:0] EN_W = 2'b11;
    localparam logic [1:0] EN_S = 2'b01;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [1:0] pins = 2'b11;
    logic       clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 sys_clk = ~sys_clk;

    key_ctrl_bank_if #(.NUM_KEYS(NK), .CNT_W(CW)) bus_w ();
    key_ctrl_bank_if #(.NUM_KEYS(NK), .CNT_W(CW)) bus_s ();

    assign bus_w.key_in  = pins;
    assign bus_w.cnt_clr = clr;
    assign bus_s.key_in  = pins;
    assign bus_s.cnt_clr = clr;

    key_ctrl_bank #(
        .NUM_KEYS(NK), .KEY_ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DEB), .REL_CYC(REL),
        .LONG_CYC(LNG), .REPEAT_CYC(RPT), .REPEAT_EN(EN_W), .CNT_W(CW), .SAT_MODE(1'b0)
    ) dut_w (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_w)
    );

    key_ctrl_bank #(
        .NUM_KEYS(NK), .KEY_ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(DEB), .REL_CYC(REL),
        .LONG_CYC(LNG), .REPEAT_CYC(RPT), .REPEAT_EN(EN_S), .CNT_W(CW), .SAT_MODE(1'b1)
    ) dut_s (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_s)
    );

    // ---------------- event model ----------------
    // Per key: run of pressed samples before acceptance, run of released
    // samples after acceptance, and the number of pressed samples counted since
    // the press began (long press at LNG, repeat every RPT beyond that).
    logic [1:0] m_s1, m_s2, m_lvl, m_press, m_long, m_rep, m_rel;
    int m_on[NK], m_off[NK], m_act[NK], m_cw[NK], m_cs[NK];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        m_press = '0; m_long = '0; m_rep = '0; m_rel = '0;
        for (int k = 0; k < NK; k++) begin
            m_on[k] = 0; m_off[k] = 0; m_act[k] = 0; m_cw[k] = 0; m_cs[k] = 0;
        end
    endtask

    task automatic model_step();
        logic [1:0] ks;
        ks = m_s2;
        for (int k = 0; k < NK; k++) begin
            if (clr) begin
                m_cw[k] = 0;
                m_cs[k] = 0;
            end else begin
                if (m_press[k] || (m_rep[k] && EN_W[k])) m_cw[k] = (m_cw[k] + 1) % (CMAX + 1);
                if (m_press[k] || (m_rep[k] && EN_S[k])) m_cs[k] = (m_cs[k] < CMAX) ? m_cs[k] + 1 : CMAX;
            end
        end
        m_press = '0; m_long = '0; m_rep = '0; m_rel = '0;
        for (int k = 0; k < NK; k++) begin
            if (!m_lvl[k]) begin
                if (ks[k]) begin
                    m_on[k]++;
                    if (m_on[k] == DEB) begin
                        m_lvl[k] = 1'b1; m_press[k] = 1'b1;
                        m_act[k] = DEB; m_on[k] = 0; m_off[k] = 0;
                    end
                end else begin
                    m_on[k] = 0;
                end
            end else if (ks[k]) begin
                m_off[k] = 0;
                m_act[k]++;
                if (m_act[k] == LNG) m_long[k] = 1'b1;
                else if (m_act[k] > LNG && ((m_act[k] - LNG) % RPT) == 0) m_rep[k] = 1'b1;
            end else begin
                m_off[k]++;
                if (m_off[k] == REL) begin
                    m_lvl[k] = 1'b0; m_rel[k] = 1'b1; m_act[k] = 0; m_off[k] = 0;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = ~pins;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic compare_model();
        logic [2*CW-1:0] ew, es;
        ew = {CW'(m_cw[1]), CW'(m_cw[0])};
        es = {CW'(m_cs[1]), CW'(m_cs[0])};
        check("model level_w", bus_w.key_level, m_lvl);
        check("model press_w", bus_w.press_pulse, m_press);
        check("model long_w", bus_w.long_pulse, m_long);
        check("model repeat_w", bus_w.repeat_pulse, m_rep);
        check("model release_w", bus_w.release_pulse, m_rel);
        check("model ctrl_w", bus_w.ctrl_val, ew);
        check("model level_s", bus_s.key_level, m_lvl);
        check("model press_s", bus_s.press_pulse, m_press);
        check("model repeat_s", bus_s.repeat_pulse, m_rep);
        check("model release_s", bus_s.release_pulse, m_rel);
        check("model ctrl_s", bus_s.ctrl_val, es);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (sys_rst_n) model_step();
        else model_reset();
        cyc++;
        compare_model();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string      name;
        logic [1:0] pin;
        logic       clr;
        logic       rst_n;
        int         n;
        logic [1:0] lvl, press, lng, rep, rel;
        int         c0w, c1w, c0s, c1s;
    } vec_t;

    vec_t rows[$];

    task automatic add(input string name, input logic [1:0] pin, input logic c, input logic r,
                       input int n, input logic [1:0] lvl, input logic [1:0] press,
                       input logic [1:0] lng, input logic [1:0] rep, input logic [1:0] rel,
                       input int c0w, input int c1w, input int c0s, input int c1s);
        vec_t v;
        v.name = name; v.pin = pin; v.clr = c; v.rst_n = r; v.n = n;
        v.lvl = lvl; v.press = press; v.lng = lng; v.rep = rep; v.rel = rel;
        v.c0w = c0w; v.c1w = c1w; v.c0s = c0s; v.c1s = c1s;
        rows.push_back(v);
    endtask

    task automatic check_row(input vec_t v);
        check({v.name, " level"}, bus_w.key_level, v.lvl);
        check({v.name, " press"}, bus_w.press_pulse, v.press);
        check({v.name, " long"}, bus_w.long_pulse, v.lng);
        check({v.name, " repeat"}, bus_w.repeat_pulse, v.rep);
        check({v.name, " release"}, bus_w.release_pulse, v.rel);
        check({v.name, " ctrl_w"}, bus_w.ctrl_val, {CW'(v.c1w), CW'(v.c0w)});
        check({v.name, " ctrl_s"}, bus_s.ctrl_val, {CW'(v.c1s), CW'(v.c0s)});
        check({v.name, " level_s"}, bus_s.key_level, v.lvl);
    endtask

    initial begin
        // Pins are active-low: 2'b10 = key0 pressed, 2'b01 = key1 pressed.
        // Pin applied in cycle a gives key_s from a+2, press strobe at a+6.
        //   name           pin    clr rst n   lvl    press  long   rep    rel    c0w c1w c0s c1s
        add("reset",        2'b11, 0, 0, 2,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t1_pre",       2'b10, 0, 1, 5,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t1_press",     2'b10, 0, 1, 1,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t1_cnt",       2'b10, 0, 1, 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);
        add("t1_rel_pre",   2'b11, 0, 1, 4,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);
        add("t1_rel",       2'b11, 0, 1, 1,  2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 1, 0);
        add("t2_glitch_on", 2'b10, 0, 1, 3,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);
        add("t2_glitch_off",2'b11, 0, 1, 6,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);
        add("t3_press",     2'b01, 0, 1, 6,  2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);
        add("t3_long_pre",  2'b01, 0, 1, 15, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 1);
        add("t3_long",      2'b01, 0, 1, 1,  2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1, 1, 1, 1);
        add("t3_rep1",      2'b01, 0, 1, 5,  2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1, 1, 1, 1);
        add("t3_rep2",      2'b01, 0, 1, 5,  2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1, 2, 1, 1);
        add("t3_rep3",      2'b01, 0, 1, 5,  2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1, 3, 1, 1);
        add("t3_cnt",       2'b01, 0, 1, 1,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 4, 1, 1);
        add("t3_release",   2'b11, 0, 1, 5,  2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1, 4, 1, 1);
        add("t4_held",      2'b10, 0, 1, 8,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2, 4, 2, 1);
        add("t4_bounce",    2'b11, 0, 1, 2,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2, 4, 2, 1);
        add("t4_back",      2'b10, 0, 1, 4,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2, 4, 2, 1);
        add("t4_long_pre",  2'b10, 0, 1, 9,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2, 4, 2, 1);
        add("t4_long",      2'b10, 0, 1, 1,  2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2, 4, 2, 1);
        add("t4_rel",       2'b11, 0, 1, 5,  2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2, 4, 2, 1);
        add("t5_clr",       2'b11, 1, 1, 1,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            add($sformatf("t5_press%0d", i), 2'b10, 0, 1, 8, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                i % (CMAX + 1), 0, (i < CMAX) ? i : CMAX, 0);
            add($sformatf("t5_rel%0d", i), 2'b11, 0, 1, 6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                i % (CMAX + 1), 0, (i < CMAX) ? i : CMAX, 0);
        end
        add("t6_press",     2'b10, 0, 1, 6,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0, 7, 0);
        add("t6_clr",       2'b10, 1, 1, 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t6_held",      2'b10, 0, 1, 3,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t6_reset",     2'b10, 0, 0, 2,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t6_redeb",     2'b10, 0, 1, 5,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t6_press2",    2'b10, 0, 1, 1,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        add("t6_cnt",       2'b10, 0, 1, 1,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);
        add("t6_release",   2'b11, 0, 1, 6,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0);

        model_reset();
        #2;
        for (int r = 0; r < rows.size(); r++) begin
            pins = rows[r].pin;
            clr  = rows[r].clr;
            if (!rows[r].rst_n) begin
                sys_rst_n = 1'b0;
                model_reset();
            end else begin
                sys_rst_n = 1'b1;
            end
            repeat (rows[r].n) tick();
            check_row(rows[r]);
        end

        // Random pin activity: toggle one or both keys, hold long enough to
        // reach long press and repeats sometimes, occasional counter clears.
        clr = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            int hold;
            pins = pins ^ 2'($urandom_range(1, 3));
            hold = $urandom_range(1, 45);
            for (int j = 0; j < hold; j++) begin
                clr = ($urandom_range(0, 39) == 0);
                tick();
            end
        end
        clr = 1'b0;
        pins = 2'b11;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
